// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and its matching detector.
//   seq_state_e    : generator FSM states
//   DefaultWidth   : default pattern length in bits
//   DefaultPattern : default serial pattern, sent MSB first
//   sat_inc()      : saturating increment for the frame counter
package seq_pkg;

  localparam int unsigned DefaultWidth = 6;
  localparam logic [DefaultWidth-1:0] DefaultPattern = 6'b101001;

  localparam int unsigned CountWidth = 4;
  localparam logic [CountWidth-1:0] CountMax = '1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] val);
    return (val == CountMax) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_shifter.sv
// Bit-index walker over a constant pattern, MSB first.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset, index returns to Width-1
//   load_i    : restart at the MSB
//   advance_i : step one bit toward bit 0, wrapping to the MSB after bit 0
//   bit_o     : pattern bit at the current index
//   last_o    : current index is bit 0 (the LSB of the frame)
// With neither load_i nor advance_i asserted the index holds.
module pattern_shifter
  import seq_pkg::*;
#(
  parameter int unsigned     Width   = DefaultWidth,
  parameter logic [Width-1:0] Pattern = DefaultPattern
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic advance_i,
  output logic bit_o,
  output logic last_o
);

  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Width - 1);

  logic [IdxW-1:0] idx_d, idx_q;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = LastIdx;
    end else if (advance_i) begin
      idx_d = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= LastIdx;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign bit_o  = Pattern[idx_q];
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/sequence_generator.sv
// Burst serial pattern generator. On an accepted start it sends i_repeat+1
// back-to-back copies of PATTERN (MSB first), then pulses o_done for one cycle.
//   i_clk         : clock, rising edge
//   i_reset       : asynchronous active-high reset, aborts any burst
//   i_start       : begin a burst, only looked at in IDLE
//   i_repeat      : frames minus one, latched when the burst starts
//   i_hold        : stall transmission while high (SEND only)
//   o_data        : pattern bit, forced to 0 when not valid
//   o_valid       : o_data carries a pattern bit
//   o_busy        : burst in progress (SEND or DONE)
//   o_frame_end   : LSB of a frame is valid this cycle
//   o_done        : one-cycle pulse after the last bit of the last frame
//   o_frame_count : completed frames in the current/most recent burst, saturating
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned      WIDTH   = DefaultWidth,
  parameter logic [WIDTH-1:0] PATTERN = DefaultPattern
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [3:0] i_repeat,
  input  logic       i_hold,
  output logic       o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_frame_end,
  output logic       o_done,
  output logic [3:0] o_frame_count
);

  seq_state_e state_d, state_q;
  logic [3:0] repeat_d, repeat_q;
  logic [3:0] count_d, count_q;
  logic       load, advance;
  logic       pat_bit, pat_last;

  pattern_shifter #(
    .Width  (WIDTH),
    .Pattern(PATTERN)
  ) u_shifter (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .load_i   (load),
    .advance_i(advance),
    .bit_o    (pat_bit),
    .last_o   (pat_last)
  );

  always_comb begin
    state_d  = state_q;
    repeat_d = repeat_q;
    count_d  = count_q;
    load     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d  = StSend;
          repeat_d = i_repeat;
          count_d  = '0;
          load     = 1'b1;
        end
      end
      StSend: begin
        if (!i_hold) begin
          advance = 1'b1;
          if (pat_last) begin
            count_d = sat_inc(count_q);
            // Compare the pre-increment count so a 16-frame burst still ends
            // even though the counter saturates at 15.
            if (count_q == repeat_q) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= StIdle;
      repeat_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      repeat_q <= repeat_d;
      count_q  <= count_d;
    end
  end

  assign o_valid       = (state_q == StSend) && !i_hold;
  assign o_data        = o_valid && pat_bit;
  assign o_frame_end   = o_valid && pat_last;
  assign o_busy        = (state_q == StSend) || (state_q == StDone);
  assign o_done        = (state_q == StDone);
  assign o_frame_count = count_q;

endmodule

// File: tb/tb_sequence_generator.sv
module tb_sequence_generator;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [3:0] i_repeat;
  logic       i_hold;
  logic       o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_frame_end;
  logic       o_done;
  logic [3:0] o_frame_count;

  sequence_generator #(
    .WIDTH  (6),
    .PATTERN(6'b101001)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_repeat     (i_repeat),
    .i_hold       (i_hold),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_frame_end  (o_frame_end),
    .o_done       (o_done),
    .o_frame_count(o_frame_count)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned cyc;
    logic        done;
    logic        data;
    logic        fend;
    logic [3:0]  fcnt;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic       det_en = 1'b0;
  logic [4:0] det_hist = '0;
  int unsigned det_cnt = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every valid or done cycle must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_reset && (o_valid || o_done)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got valid=%0b done=%0b, required none (cyc=%0d)",
                   o_valid, o_done, cyc);
        end else begin
          e = exp_q.pop_front();
          compare("out_cycle", 32'(cyc), 32'(e.cyc));
          compare("out_fields",
                  {23'd0, o_done, o_valid, o_data, o_frame_end, o_busy, o_frame_count},
                  {23'd0, e.done, ~e.done, e.data, e.fend, 1'b1, e.fcnt});
        end
        // Loopback sequence detector on the gated serial stream.
        if (det_en && o_valid) begin
          if ({det_hist, o_data} == 6'b101001) begin
            det_cnt++;
            compare("det_align_frame_end", {31'd0, o_frame_end}, 32'd1);
          end
          det_hist = {det_hist[3:0], o_data};
        end
      end
    end
  end

  // Expected stream for a burst whose first bit lands in cycle c0. A hold of
  // hold_len cycles is inserted before bit number hold_at of the burst.
  task automatic push_burst(input int unsigned c0, input int unsigned frames,
                            input int unsigned hold_at, input int unsigned hold_len);
    logic [5:0] pat;
    exp_t e;
    int unsigned t;
    pat = 6'b101001;
    t = c0;
    for (int unsigned f = 0; f < frames; f++) begin
      for (int unsigned b = 0; b < 6; b++) begin
        if (f * 6 + b == hold_at) t += hold_len;
        e.cyc  = t;
        e.done = 1'b0;
        e.data = pat[5-b];
        e.fend = (b == 5);
        e.fcnt = 4'(f);
        exp_q.push_back(e);
        t++;
      end
    end
    e.cyc  = t;
    e.done = 1'b1;
    e.data = 1'b0;
    e.fend = 1'b0;
    e.fcnt = (frames > 15) ? 4'd15 : 4'(frames);
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns the cycle label of the first bit.
  task automatic start_burst(input logic [3:0] rep, output int unsigned c0);
    i_repeat = rep;
    i_start  = 1'b1;
    @(posedge i_clk);
    #1;
    c0 = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  localparam int unsigned NoHold = 32'hFFFF;

  initial begin
    int unsigned c0;
    int unsigned c1;

    i_reset  = 1'b1;
    i_start  = 1'b0;
    i_repeat = 4'd0;
    i_hold   = 1'b0;
    #2;
    compare("reset_outputs", {23'd0, o_data, o_valid, o_busy, o_frame_end, o_done, o_frame_count},
            32'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // Single frame.
    start_burst(4'd0, c0);
    push_burst(c0, 1, NoHold, 0);
    wait_drain(40);
    compare("idle_count_after_1", {28'd0, o_frame_count}, 32'd1);
    compare("idle_busy_after_1", {31'd0, o_busy}, 32'd0);

    // Three frames back to back.
    start_burst(4'd2, c0);
    push_burst(c0, 3, NoHold, 0);
    wait_drain(60);
    compare("idle_count_after_3", {28'd0, o_frame_count}, 32'd3);

    // Hold for three cycles after the second bit.
    start_burst(4'd0, c0);
    push_burst(c0, 1, 2, 3);
    wait_cyc(c0 + 2);
    i_hold = 1'b1;
    wait_cyc(c0 + 5);
    i_hold = 1'b0;
    wait_drain(40);

    // Reset during frame 2 of a 4-frame burst.
    start_burst(4'd3, c0);
    push_burst(c0, 4, NoHold, 0);
    wait_cyc(c0 + 8);
    i_reset = 1'b1;
    #1;
    exp_q.delete();
    compare("abort_outputs", {23'd0, o_data, o_valid, o_busy, o_frame_end, o_done, o_frame_count},
            32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    compare("abort_idle_busy", {31'd0, o_busy}, 32'd0);
    start_burst(4'd1, c0);
    push_burst(c0, 2, NoHold, 0);
    wait_drain(40);

    // Start held high; i_repeat changed mid-burst only affects the next burst.
    i_repeat = 4'd0;
    i_start  = 1'b1;
    @(posedge i_clk);
    #1;
    c0 = cyc;
    c1 = c0 + 8;
    push_burst(c0, 1, NoHold, 0);
    push_burst(c1, 3, NoHold, 0);
    wait_cyc(c0 + 2);
    i_repeat = 4'd2;
    wait_cyc(c0 + 9);
    i_start = 1'b0;
    wait_drain(60);
    compare("idle_count_restart", {28'd0, o_frame_count}, 32'd3);

    // 16 frames: counter saturates at 15.
    start_burst(4'd15, c0);
    push_burst(c0, 16, NoHold, 0);
    wait_drain(200);
    compare("idle_count_sat", {28'd0, o_frame_count}, 32'd15);

    // Loopback into the detector.
    det_hist = '0;
    det_cnt  = 0;
    det_en   = 1'b1;
    start_burst(4'd4, c0);
    push_burst(c0, 5, NoHold, 0);
    wait_drain(80);
    det_en = 1'b0;
    compare("det_found_count", 32'(det_cnt), 32'd5);

    repeat (3) @(posedge i_clk);
    #1;
    compare("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning pattern length in bits.
REQ-002 SHALL have parameter PATTERN, default 6'b101001, meaning the serial pattern to transmit, MSB first.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port i_start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port i_repeat, input, 4, burst length minus one (frames = i_repeat+1); latched on accepted start.
REQ-007 SHALL have port i_hold, input, 1, stall; freezes transmission while high.
REQ-008 SHALL have port o_data, output, 1, serial pattern bit.
REQ-009 SHALL have port o_valid, output, 1, o_data carries a pattern bit this cycle.
REQ-010 SHALL have port o_busy, output, 1, high in SEND and DONE.
REQ-011 SHALL have port o_frame_end, output, 1, high on the cycle the last bit (LSB) of a frame is valid.
REQ-012 SHALL have port o_done, output, 1, single-cycle pulse after the last bit of the last frame.
REQ-013 SHALL have port o_frame_count, output, 4, number of completed frames in the current or most recent burst.

Function
REQ-014 SHALL implement FSM states IDLE, SEND and DONE.
REQ-015 In IDLE with i_start=1 at an edge, the FSM SHALL move to SEND, load the bit index to WIDTH-1, latch i_repeat and clear o_frame_count.
REQ-016 The first bit, PATTERN[WIDTH-1], SHALL be valid in the first cycle after the accepting edge (latency 1).
REQ-017 In SEND with i_hold=0, each edge SHALL advance the bit index by one toward bit 0; at bit 0 it SHALL wrap to WIDTH-1 for the next frame.
REQ-018 Consecutive frames SHALL be sent back-to-back with no idle gap (e.g. 101001101001 for two frames).
REQ-019 In SEND with i_hold=1, o_valid SHALL be 0, and the bit index, frame counter and latched repeat SHALL hold; transmission SHALL resume on the same bit after i_hold falls.
REQ-020 o_data SHALL be 0 whenever o_valid=0.
REQ-021 o_frame_count SHALL increment on the edge that ends a valid, non-held LSB cycle; it SHALL saturate at 15 and SHALL NOT wrap.
REQ-022 After the LSB of frame i_repeat+1, the FSM SHALL enter DONE; o_done=1 for exactly that cycle, then IDLE.
REQ-023 i_start in SEND or DONE SHALL be ignored; a new burst SHALL require i_start in IDLE, so the earliest restart is the cycle after o_done.
REQ-024 i_hold in IDLE or DONE SHALL have no effect.
REQ-025 With no hold, a burst of N frames SHALL produce exactly N*WIDTH consecutive o_valid cycles followed by one o_done cycle.

Reset
REQ-026 i_reset=1 SHALL asynchronously force IDLE, bit index WIDTH-1, o_data=0, o_valid=0, o_busy=0, o_frame_end=0, o_done=0 and o_frame_count=0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no o_done pulse; the first i_start after reset release SHALL start a fresh burst.

Structure
REQ-028 A shared package seq_pkg SHALL hold the state typedef (IDLE/SEND/DONE), the default WIDTH and the default PATTERN constant, for reuse by the detector side.
REQ-029 The shift/index logic SHALL be a single sub-module, pattern_shifter (load, advance, hold, last-bit flag); the FSM and frame counter SHALL stay in sequence_generator.

Verification
REQ-030 Reset, then i_start=1 for 1 cycle with i_repeat=0 -> o_data 1,0,1,0,0,1 with o_valid=1 on 6 cycles, o_frame_end on the 6th, o_done on the 7th, o_frame_count=1.
REQ-031 i_repeat=2 -> 18 consecutive valid bits 101001101001101001, three o_frame_end pulses, o_frame_count=3, one o_done.
REQ-032 i_hold=1 for 3 cycles after the 2nd bit -> o_valid=0 for those 3 cycles, then resumption at bit 3 (1); total span is 6+3 cycles before o_done.
REQ-033 i_reset pulsed during frame 2 of a 4-frame burst -> all outputs 0 immediately, no o_done; the next i_start produces a full fresh burst.
REQ-034 i_start held high throughout a burst with i_repeat=0 -> a second burst starts only in the cycle after o_done; i_repeat changed mid-burst has no effect.
REQ-035 Loopback: o_data (gated by o_valid) into the 101001 sequence detector, i_repeat=4 -> exactly 5 detector pattern-found pulses, each aligned with o_frame_end.
